// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add cell (two half-add stages plus a carry OR)
// processes one bit per cycle, with the result presented on a valid/ready handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             c;
   logic [CW-1:0]    cnt;

   logic             h1_s;
   logic             h1_c;
   logic             h2_s;
   logic             h2_c;
   logic             c_next;
   logic [WIDTH:0]   res_cat;
   logic [WIDTH-1:0] res_next;

   // Full-add cell on the current LSBs; the new sum bit enters the result MSB.
   // The WIDTH+1 concat keeps the shift legal when WIDTH is 1.
   always_comb begin
      h1_s     = a_sr[0] ^ b_sr[0];
      h1_c     = a_sr[0] & b_sr[0];
      h2_s     = h1_s ^ c;
      h2_c     = h1_s & c;
      c_next   = h1_c | h2_c;
      res_cat  = {h2_s, res_sr};
      res_next = res_cat[WIDTH:1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         c         <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  c      <= cin;
                  res_sr <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               c      <= c_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum       <= res_next;
                  cout      <= c_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the scenarios and a
// 4-bit instance swept over every operand/carry-in combination.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;

   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       cin4;
   logic       busy4;
   logic       out_valid4;
   logic       out_ready4;
   logic [3:0] sum4;
   logic       cout4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic begin_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
      a = va; b = vb; cin = vc; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      tests++; if (sum !== 8'h00)      begin fails++; $display("FAIL reset_sum got %h want 00", sum); end
      tests++; if (cout !== 1'b0)      begin fails++; $display("FAIL reset_cout got %0b want 0", cout); end
   endtask

   task automatic test_carry_out();
      int n;
      out_ready = 1'b0;
      begin_op(8'hFF, 8'h01, 1'b0);
      n = 0;
      while (!out_valid && n < 40) begin
         tests++; if (busy !== 1'b1) begin fails++; $display("FAIL carry_busy_run cyc %0d got %0b want 1", n, busy); end
         tick();
         n++;
      end
      tests++; if (n != 8)        begin fails++; $display("FAIL carry_latency got %0d want 8", n); end
      tests++; if (sum !== 8'h00) begin fails++; $display("FAIL carry_sum got %h want 00", sum); end
      tests++; if (cout !== 1'b1) begin fails++; $display("FAIL carry_cout got %0b want 1", cout); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL carry_busy_done got %0b want 1", busy); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL carry_valid_drop got %0b want 0", out_valid); end
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL carry_busy_drop got %0b want 0", busy); end
   endtask

   task automatic test_carry_chain();
      int n;
      begin_op(8'h5A, 8'hA5, 1'b1);
      wait_valid(n);
      tests++; if (n != 8)        begin fails++; $display("FAIL chain_latency got %0d want 8", n); end
      tests++; if (sum !== 8'h00) begin fails++; $display("FAIL chain_sum got %h want 00", sum); end
      tests++; if (cout !== 1'b1) begin fails++; $display("FAIL chain_cout got %0b want 1", cout); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      begin_op(8'h00, 8'h00, 1'b0);
      wait_valid(n);
      tests++; if (n != 8)        begin fails++; $display("FAIL zero_latency got %0d want 8", n); end
      tests++; if (sum !== 8'h00) begin fails++; $display("FAIL zero_sum got %h want 00", sum); end
      tests++; if (cout !== 1'b0) begin fails++; $display("FAIL zero_cout got %0b want 0", cout); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      begin_op(8'h3C, 8'h0F, 1'b0);
      // Operand changes and a stray start during RUN must not disturb the result.
      a = 8'hFF; b = 8'hFF; cin = 1'b1;
      tick();
      a = 8'h11; start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(n);
      tests++; if (n != 6) begin fails++; $display("FAIL bp_latency got %0d want 6", n); end
      for (int i = 0; i < 5; i++) begin
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cyc %0d got %0b want 1", i, out_valid); end
         tests++; if (sum !== 8'h4B)      begin fails++; $display("FAIL bp_sum cyc %0d got %h want 4b", i, sum); end
         tests++; if (cout !== 1'b0)      begin fails++; $display("FAIL bp_cout cyc %0d got %0b want 0", i, cout); end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_drop got %0b want 0", out_valid); end
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL bp_busy_drop got %0b want 0", busy); end
      tick();
      tests++; if (sum !== 8'h4B) begin fails++; $display("FAIL bp_sum_hold_idle got %h want 4b", sum); end
   endtask

   task automatic test_reset_mid();
      int n;
      begin_op(8'h12, 8'h34, 1'b0);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rmid_busy got %0b want 0", busy); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %0b want 0", out_valid); end
      tests++; if (sum !== 8'h00)      begin fails++; $display("FAIL rmid_sum got %h want 00", sum); end
      tests++; if (cout !== 1'b0)      begin fails++; $display("FAIL rmid_cout got %0b want 0", cout); end
      begin_op(8'h80, 8'h80, 1'b0);
      wait_valid(n);
      tests++; if (n != 8)        begin fails++; $display("FAIL rpost_latency got %0d want 8", n); end
      tests++; if (sum !== 8'h00) begin fails++; $display("FAIL rpost_sum got %h want 00", sum); end
      tests++; if (cout !== 1'b1) begin fails++; $display("FAIL rpost_cout got %0b want 1", cout); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] va [3] = '{8'h12, 8'hFF, 8'h80};
      logic [7:0] vb [3] = '{8'h34, 8'hFF, 8'h7F};
      logic       vc [3] = '{1'b0, 1'b1, 1'b1};
      logic [7:0] es [3] = '{8'h46, 8'hFF, 8'h00};
      logic       ec [3] = '{1'b0, 1'b1, 1'b1};
      int n;
      out_ready = 1'b1;
      a = va[0]; b = vb[0]; cin = vc[0]; start = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         wait_valid(n);
         tests++; if (n != 8)       begin fails++; $display("FAIL b2b_latency op %0d got %0d want 8", i, n); end
         tests++; if (sum !== es[i]) begin fails++; $display("FAIL b2b_sum op %0d got %h want %h", i, sum, es[i]); end
         tests++; if (cout !== ec[i]) begin fails++; $display("FAIL b2b_cout op %0d got %0b want %0b", i, cout, ec[i]); end
         if (i < 2) begin
            a = va[i+1]; b = vb[i+1]; cin = vc[i+1];
         end else begin
            start = 1'b0;
         end
         tick();
         tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle op %0d got busy %0b want 0", i, busy); end
         tick();
         tests++; if (busy !== (i < 2)) begin fails++; $display("FAIL b2b_restart op %0d got busy %0b want %0b", i, busy, (i < 2)); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_exhaustive();
      int n;
      logic [4:0] exp;
      out_ready4 = 1'b1;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
               tick();
               start4 = 1'b0;
               n = 0;
               while (!out_valid4 && n < 20) begin
                  tick();
                  n++;
               end
               exp = 5'(ia + ib + ic);
               tests++;
               if (n != 4 || {cout4, sum4} !== exp) begin
                  fails++;
                  $display("FAIL exh a=%h b=%h cin=%0d got %h after %0d cyc want %h after 4", ia, ib, ic, {cout4, sum4}, n, exp);
               end
               tick();
            end
         end
      end
      out_ready4 = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
      tick();
      test_reset();
      test_carry_out();
      test_carry_chain();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_exhaustive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
